// File: rtl/mem_stage_ctrl_if.sv
// Bus bundle between the E stage, data memory and WB for mem_stage_ctrl.
// The DUT uses the slave modport; the driving environment uses master.
interface mem_stage_ctrl_if #(
  parameter int AW    = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_cmp;
  logic [AW-1:0]    in_addr;
  logic             flush;
  logic             mem_ack;
  logic             in_ready;
  logic             mem_req;
  logic             mem_we;
  logic [1:0]       mem_size;
  logic [2:0]       load_type;
  logic             hilo_sel;
  logic             cp0_we;
  logic             out_valid;
  logic [31:0]      out_instr;
  logic             out_cmp;
  logic             exc_align;
  logic             exc_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_instr, in_cmp, in_addr, flush, mem_ack,
    input  in_ready, mem_req, mem_we, mem_size, load_type, hilo_sel, cp0_we,
           out_valid, out_instr, out_cmp, exc_align, exc_timeout, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_cmp, in_addr, flush, mem_ack,
    output in_ready, mem_req, mem_we, mem_size, load_type, hilo_sel, cp0_we,
           out_valid, out_instr, out_cmp, exc_align, exc_timeout, stall_cnt
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: holds the E-stage result, sequences one data
// memory access per load/store with timeout, and flags misaligned accesses.
module mem_stage_ctrl #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              reset,
  mem_stage_ctrl_if.slave  bus
);

  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_SPEC  = 6'h00;
  localparam logic [4:0] RS_MT    = 5'h04;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: is_mem = 1'b1;
      default:                                                  is_mem = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] size_of(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:         size_of = 2'b10;
      OP_LH, OP_LHU, OP_SH: size_of = 2'b01;
      default:              size_of = 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] ltype_of(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:  ltype_of = 3'd0;
      OP_LH, OP_SH:  ltype_of = 3'd1;
      OP_LHU, OP_SB: ltype_of = 3'd2;
      OP_LB:         ltype_of = 3'd3;
      OP_LBU:        ltype_of = 3'd4;
      default:       ltype_of = 3'd0;
    endcase
  endfunction

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
    case (size_of(op))
      2'b10:   is_misaligned = (lo != 2'b00);
      2'b01:   is_misaligned = lo[0];
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  state_t            state_r, state_nxt_s;
  logic              valid_r;
  logic [31:0]       instr_r;
  logic              cmp_r;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_nxt_s;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              align_r;
  logic              timeout_r;

  logic              idle_s;
  logic              wait_s;
  logic              in_take_s;
  logic [5:0]        in_op_s;
  logic [5:0]        op_r_s;
  logic              misalign_s;
  logic              start_s;
  logic              align_hit_s;
  logic              timeout_hit_s;
  logic              out_valid_s;

  assign idle_s      = (state_r == ST_IDLE);
  assign wait_s      = (state_r == ST_WAIT);
  assign in_take_s   = bus.in_valid & ~bus.flush;
  assign in_op_s     = bus.in_instr[31:26];
  assign op_r_s      = instr_r[31:26];
  assign misalign_s  = is_misaligned(in_op_s, bus.in_addr[1:0]);
  assign start_s     = idle_s & in_take_s & is_mem(in_op_s) & ~misalign_s;
  assign align_hit_s = idle_s & in_take_s & is_mem(in_op_s) & misalign_s;

  // Next-state logic; flush overrides ack/timeout, ack overrides timeout.
  always_comb begin
    state_nxt_s   = state_r;
    to_cnt_nxt_s  = to_cnt_r;
    timeout_hit_s = 1'b0;
    if (bus.flush) begin
      state_nxt_s  = ST_IDLE;
      to_cnt_nxt_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          to_cnt_nxt_s = '0;
          if (start_s) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (bus.mem_ack) begin
            state_nxt_s  = ST_IDLE;
            to_cnt_nxt_s = '0;
          end else if (to_cnt_r == TO_LAST) begin
            state_nxt_s   = ST_IDLE;
            to_cnt_nxt_s  = '0;
            timeout_hit_s = 1'b1;
          end else begin
            state_nxt_s  = ST_WAIT;
            to_cnt_nxt_s = to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_nxt_s  = ST_IDLE;
          to_cnt_nxt_s = '0;
        end
      endcase
    end
  end

  // FSM state and timeout counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      to_cnt_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      to_cnt_r <= to_cnt_nxt_s;
    end
  end

  // Stage register: loads whenever the stage is ready, cleared by flush otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      instr_r <= 32'h0000_0000;
      cmp_r   <= 1'b0;
    end else if (idle_s) begin
      valid_r <= in_take_s;
      instr_r <= in_take_s ? bus.in_instr : 32'h0000_0000;
      cmp_r   <= bus.in_cmp;
    end else if (bus.flush) begin
      valid_r <= 1'b0;
      instr_r <= 32'h0000_0000;
    end
  end

  // Exception pulses and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      align_r     <= 1'b0;
      timeout_r   <= 1'b0;
      stall_cnt_r <= '0;
    end else begin
      align_r   <= align_hit_s;
      timeout_r <= timeout_hit_s;
      if (wait_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid_s     = valid_r & idle_s;

  assign bus.in_ready    = idle_s;
  assign bus.mem_req     = wait_s;
  assign bus.mem_we      = wait_s & is_store(op_r_s);
  assign bus.mem_size    = size_of(op_r_s);
  assign bus.load_type   = ltype_of(op_r_s);
  assign bus.out_valid   = out_valid_s;
  assign bus.out_instr   = instr_r;
  assign bus.out_cmp     = cmp_r;
  assign bus.cp0_we      = out_valid_s & (op_r_s == OP_COP0) & (instr_r[25:21] == RS_MT);
  assign bus.hilo_sel    = out_valid_s & (op_r_s == OP_SPEC)
                           & ((instr_r[5:0] == FN_MFHI) | (instr_r[5:0] == FN_MFLO));
  assign bus.exc_align   = align_r;
  assign bus.exc_timeout = timeout_r;
  assign bus.stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (TIMEOUT=4).
module tb_mem_stage_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_stage_ctrl_if #(.AW(32), .CNT_W(16)) bus ();

  mem_stage_ctrl #(.AW(32), .TIMEOUT(4), .TO_W(8), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    bus.in_cmp   = 1'b0;
    bus.in_addr  = 32'h0;
    bus.flush    = 1'b0;
    bus.mem_ack  = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] addr, input logic cmp);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_addr  = addr;
    bus.in_cmp   = cmp;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_in();
    step();
    step();
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_stall", {16'b0, bus.stall_cnt}, 32'd0);
    chk("rst_size", {30'b0, bus.mem_size}, 32'd0);
    reset = 1'b0;

    // lw aligned, ack in third WAIT cycle
    issue(32'h8C08_0004, 32'h10, 1'b1);
    step();
    idle_in();
    chk("lw_req1", {31'b0, bus.mem_req}, 32'd1);
    chk("lw_we", {31'b0, bus.mem_we}, 32'd0);
    chk("lw_size", {30'b0, bus.mem_size}, 32'd2);
    chk("lw_ltype", {29'b0, bus.load_type}, 32'd0);
    chk("lw_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("lw_oval_wait", {31'b0, bus.out_valid}, 32'd0);
    chk("lw_cmp", {31'b0, bus.out_cmp}, 32'd1);
    step();
    chk("lw_req2", {31'b0, bus.mem_req}, 32'd1);
    step();
    chk("lw_req3", {31'b0, bus.mem_req}, 32'd1);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("lw_req_done", {31'b0, bus.mem_req}, 32'd0);
    chk("lw_oval", {31'b0, bus.out_valid}, 32'd1);
    chk("lw_oinstr", bus.out_instr, 32'h8C08_0004);
    chk("lw_stall", {16'b0, bus.stall_cnt}, 32'd3);

    // sb, ack in the first WAIT cycle
    issue(32'hA128_0003, 32'h13, 1'b0);
    step();
    idle_in();
    chk("sb_req", {31'b0, bus.mem_req}, 32'd1);
    chk("sb_we", {31'b0, bus.mem_we}, 32'd1);
    chk("sb_size", {30'b0, bus.mem_size}, 32'd0);
    chk("sb_ltype", {29'b0, bus.load_type}, 32'd2);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("sb_req_done", {31'b0, bus.mem_req}, 32'd0);
    chk("sb_oval", {31'b0, bus.out_valid}, 32'd1);
    chk("sb_stall", {16'b0, bus.stall_cnt}, 32'd4);

    // lh misaligned
    issue(32'h8509_0002, 32'h11, 1'b0);
    step();
    idle_in();
    chk("lh_req", {31'b0, bus.mem_req}, 32'd0);
    chk("lh_align", {31'b0, bus.exc_align}, 32'd1);
    chk("lh_oval", {31'b0, bus.out_valid}, 32'd1);
    chk("lh_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    chk("lh_align_off", {31'b0, bus.exc_align}, 32'd0);
    chk("lh_oval_off", {31'b0, bus.out_valid}, 32'd0);

    // sw with no ack -> timeout after 4 WAIT cycles
    issue(32'hAD0A_0008, 32'h20, 1'b0);
    step();
    idle_in();
    chk("sw_we", {31'b0, bus.mem_we}, 32'd1);
    chk("sw_size", {30'b0, bus.mem_size}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("sw_req", {31'b0, bus.mem_req}, 32'd1);
      chk("sw_no_to", {31'b0, bus.exc_timeout}, 32'd0);
      step();
    end
    chk("sw_req4", {31'b0, bus.mem_req}, 32'd1);
    step();
    chk("sw_to", {31'b0, bus.exc_timeout}, 32'd1);
    chk("sw_req_off", {31'b0, bus.mem_req}, 32'd0);
    chk("sw_oval", {31'b0, bus.out_valid}, 32'd1);
    chk("sw_stall", {16'b0, bus.stall_cnt}, 32'd8);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("late_ack_to", {31'b0, bus.exc_timeout}, 32'd0);
    chk("late_ack_req", {31'b0, bus.mem_req}, 32'd0);
    chk("late_ack_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("late_ack_stall", {16'b0, bus.stall_cnt}, 32'd8);

    // ack coinciding with the last allowed WAIT cycle: ack wins
    issue(32'h8C08_0004, 32'h10, 1'b0);
    step();
    idle_in();
    step();
    step();
    step();
    chk("edge_req4", {31'b0, bus.mem_req}, 32'd1);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("edge_no_to", {31'b0, bus.exc_timeout}, 32'd0);
    chk("edge_oval", {31'b0, bus.out_valid}, 32'd1);
    chk("edge_stall", {16'b0, bus.stall_cnt}, 32'd12);

    // lbu then flush during WAIT, then mtc0
    issue(32'h9109_0001, 32'h01, 1'b0);
    step();
    idle_in();
    chk("lbu_ltype", {29'b0, bus.load_type}, 32'd4);
    chk("lbu_req", {31'b0, bus.mem_req}, 32'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl_req", {31'b0, bus.mem_req}, 32'd0);
    chk("fl_oval", {31'b0, bus.out_valid}, 32'd0);
    chk("fl_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("fl_instr", bus.out_instr, 32'h0);
    chk("fl_stall", {16'b0, bus.stall_cnt}, 32'd13);
    issue(32'h4088_6000, 32'h0, 1'b0);
    step();
    idle_in();
    chk("mtc0_we", {31'b0, bus.cp0_we}, 32'd1);
    chk("mtc0_oval", {31'b0, bus.out_valid}, 32'd1);
    step();
    chk("mtc0_we_off", {31'b0, bus.cp0_we}, 32'd0);

    // flush beats in_valid in the same cycle
    issue(32'h8C08_0004, 32'h10, 1'b0);
    bus.flush = 1'b1;
    step();
    idle_in();
    chk("flv_req", {31'b0, bus.mem_req}, 32'd0);
    chk("flv_oval", {31'b0, bus.out_valid}, 32'd0);
    chk("flv_instr", bus.out_instr, 32'h0);

    // mfhi
    issue(32'h0000_4010, 32'h0, 1'b0);
    step();
    idle_in();
    chk("mfhi_sel", {31'b0, bus.hilo_sel}, 32'd1);
    chk("mfhi_cp0", {31'b0, bus.cp0_we}, 32'd0);
    step();
    chk("mfhi_sel_off", {31'b0, bus.hilo_sel}, 32'd0);

    // reset in the middle of WAIT overrides ack and in_valid
    issue(32'h8C08_0004, 32'h10, 1'b1);
    step();
    chk("rw_req", {31'b0, bus.mem_req}, 32'd1);
    reset = 1'b1;
    bus.mem_ack = 1'b1;
    step();
    chk("rw_req_off", {31'b0, bus.mem_req}, 32'd0);
    chk("rw_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rw_stall", {16'b0, bus.stall_cnt}, 32'd0);
    chk("rw_oval", {31'b0, bus.out_valid}, 32'd0);
    chk("rw_instr", bus.out_instr, 32'h0);
    chk("rw_cmp", {31'b0, bus.out_cmp}, 32'd0);
    reset = 1'b0;
    idle_in();
    step();
    chk("post_rst_req", {31'b0, bus.mem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
